// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues requests to instruction
// memory, delivers fetched instructions with zero added latency, and
// handles stalls, branch redirects (with draining of an in-flight
// request) and HALT.
module fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  input  logic [15:0] imem_rdata,
  input  logic        imem_done,
  output logic        imem_en,
  output logic [15:0] imem_addr,
  output logic [15:0] instruction,
  output logic [15:0] next_pc1,
  output logic        fetch_valid,
  output logic        fetch_stall,
  output logic        halted
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [15:0] pc_r;
  logic [15:0] pc_nxt_s;
  // Address of the request still in flight after a redirect; the memory
  // must keep seeing it until it completes, even though pc already moved.
  logic [15:0] drain_addr_r;
  logic [15:0] drain_addr_nxt_s;
  logic        is_halt_s;

  // HALT is any instruction whose 5-bit opcode field is all zeros.
  function automatic logic opcode_is_halt(input logic [15:0] instr);
    return (instr[15:11] == 5'b00000);
  endfunction

  assign is_halt_s = opcode_is_halt(imem_rdata);
  assign next_pc1  = pc_r + 16'd2;

  // State, PC and drain-address registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= FETCH;
      pc_r         <= RESET_PC;
      drain_addr_r <= RESET_PC;
    end else begin
      state_r      <= state_nxt_s;
      pc_r         <= pc_nxt_s;
      drain_addr_r <= drain_addr_nxt_s;
    end
  end

  // Next-state and next-PC selection; a redirect outranks everything else.
  always_comb begin
    state_nxt_s      = state_r;
    pc_nxt_s         = pc_r;
    drain_addr_nxt_s = drain_addr_r;
    case (state_r)
      FETCH: begin
        if (branch_taken) begin
          pc_nxt_s = branch_target;
          if (imem_done) begin
            state_nxt_s = FETCH;
          end else begin
            // Request to the old pc is still outstanding; wait it out.
            state_nxt_s      = DRAIN;
            drain_addr_nxt_s = pc_r;
          end
        end else if (stall) begin
          pc_nxt_s = pc_r;
        end else if (imem_done) begin
          if (is_halt_s) begin
            state_nxt_s = HALTED;
          end else begin
            pc_nxt_s = next_pc1;
          end
        end else begin
          pc_nxt_s = pc_r;
        end
      end
      DRAIN: begin
        if (branch_taken) begin
          pc_nxt_s = branch_target;
        end else begin
          pc_nxt_s = pc_r;
        end
        if (imem_done) begin
          state_nxt_s = FETCH;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      HALTED: begin
        // Only a redirect (a wrong-path HALT being cancelled) leaves HALTED.
        if (branch_taken) begin
          pc_nxt_s    = branch_target;
          state_nxt_s = FETCH;
        end else begin
          state_nxt_s = HALTED;
        end
      end
      default: begin
        state_nxt_s = FETCH;
        pc_nxt_s    = RESET_PC;
      end
    endcase
  end

  // Memory request and downstream outputs; quiet while reset is asserted.
  always_comb begin
    imem_en     = 1'b0;
    imem_addr   = pc_r;
    instruction = NOP_INSTR;
    fetch_valid = 1'b0;
    fetch_stall = 1'b0;
    halted      = 1'b0;
    if (rst) begin
      imem_en = 1'b0;
    end else begin
      case (state_r)
        FETCH: begin
          imem_en     = 1'b1;
          imem_addr   = pc_r;
          fetch_stall = ~imem_done;
          if (imem_done && !branch_taken) begin
            instruction = imem_rdata;
            fetch_valid = 1'b1;
          end else begin
            instruction = NOP_INSTR;
            fetch_valid = 1'b0;
          end
        end
        DRAIN: begin
          imem_en     = 1'b1;
          imem_addr   = drain_addr_r;
          fetch_stall = 1'b1;
        end
        HALTED: begin
          halted = 1'b1;
        end
        default: begin
          imem_en = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: inputs change on the falling edge and
// outputs are checked 1 ns later, before the next rising edge.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic [15:0] imem_rdata;
  logic        imem_done;
  logic        imem_en;
  logic [15:0] imem_addr;
  logic [15:0] instruction;
  logic [15:0] next_pc1;
  logic        fetch_valid;
  logic        fetch_stall;
  logic        halted;

  int vectors = 0;
  int miscompares = 0;

  fetch_stage #(.RESET_PC(16'h0000), .NOP_INSTR(16'h0800)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_rdata   (imem_rdata),
    .imem_done    (imem_done),
    .imem_en      (imem_en),
    .imem_addr    (imem_addr),
    .instruction  (instruction),
    .next_pc1     (next_pc1),
    .fetch_valid  (fetch_valid),
    .fetch_stall  (fetch_stall),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs at the falling edge, then settle.
  task automatic drive(input logic st, input logic br, input logic [15:0] tgt,
                       input logic done, input logic [15:0] rdata);
    @(negedge clk);
    rst           = 1'b0;
    stall         = st;
    branch_taken  = br;
    branch_target = tgt;
    imem_done     = done;
    imem_rdata    = rdata;
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 16'h0000;
    imem_done = 1'b0; imem_rdata = 16'h0000;
    #1;
    // Reset outputs
    chk("rst_en",    {15'd0, imem_en},     16'h0000);
    chk("rst_instr", instruction,          16'h0800);
    chk("rst_valid", {15'd0, fetch_valid}, 16'h0000);
    chk("rst_fstall",{15'd0, fetch_stall}, 16'h0000);
    chk("rst_halt",  {15'd0, halted},      16'h0000);
    chk("rst_npc",   next_pc1,             16'h0002);

    // Zero-wait stream
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'h4000);
    chk("zw0_en",    {15'd0, imem_en},     16'h0001);
    chk("zw0_addr",  imem_addr,            16'h0000);
    chk("zw0_instr", instruction,          16'h4000);
    chk("zw0_valid", {15'd0, fetch_valid}, 16'h0001);
    chk("zw0_npc",   next_pc1,             16'h0002);
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'h4001);
    chk("zw1_addr",  imem_addr,            16'h0002);
    chk("zw1_instr", instruction,          16'h4001);
    chk("zw1_npc",   next_pc1,             16'h0004);
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'h4002);
    chk("zw2_addr",  imem_addr,            16'h0004);

    // Three-cycle memory wait at 0006
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'h1234);
      chk("wait_addr",  imem_addr,            16'h0006);
      chk("wait_fst",   {15'd0, fetch_stall}, 16'h0001);
      chk("wait_instr", instruction,          16'h0800);
      chk("wait_valid", {15'd0, fetch_valid}, 16'h0000);
    end
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'h4003);
    chk("wdone_instr", instruction,          16'h4003);
    chk("wdone_valid", {15'd0, fetch_valid}, 16'h0001);
    chk("wdone_fst",   {15'd0, fetch_stall}, 16'h0000);

    // Redirect with data ready at 0008 -> 0010
    drive(1'b0, 1'b1, 16'h0010, 1'b1, 16'h4004);
    chk("br8_addr",  imem_addr,            16'h0008);
    chk("br8_valid", {15'd0, fetch_valid}, 16'h0000);

    // Stall two cycles at 0010
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 16'h0000, 1'b1, 16'h4005);
      chk("stl_addr",  imem_addr,            16'h0010);
      chk("stl_valid", {15'd0, fetch_valid}, 16'h0001);
    end
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'h4005);
    chk("unstl_addr", imem_addr, 16'h0010);

    // Branch plus stall in the same cycle at 0012
    drive(1'b1, 1'b1, 16'h0040, 1'b1, 16'h4006);
    chk("bst_addr",  imem_addr,            16'h0012);
    chk("bst_valid", {15'd0, fetch_valid}, 16'h0000);

    // Branch during a pending fetch at 0040, re-branch in DRAIN
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    chk("b40_addr", imem_addr, 16'h0040);
    drive(1'b0, 1'b1, 16'h0070, 1'b0, 16'h0000);
    chk("bpend_valid", {15'd0, fetch_valid}, 16'h0000);
    chk("bpend_fst",   {15'd0, fetch_stall}, 16'h0001);
    drive(1'b0, 1'b1, 16'h0080, 1'b0, 16'h0000);
    chk("dr0_addr",  imem_addr,            16'h0040);
    chk("dr0_en",    {15'd0, imem_en},     16'h0001);
    chk("dr0_npc",   next_pc1,             16'h0072);
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    chk("dr1_addr",  imem_addr,            16'h0040);
    chk("dr1_npc",   next_pc1,             16'h0082);
    chk("dr1_fst",   {15'd0, fetch_stall}, 16'h0001);
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'h4007);
    chk("dr2_instr", instruction,          16'h0800);
    chk("dr2_valid", {15'd0, fetch_valid}, 16'h0000);
    drive(1'b0, 1'b1, 16'h0020, 1'b1, 16'h4008);
    chk("post_dr_addr", imem_addr, 16'h0080);

    // HALT at 0020
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000);
    chk("hlt_addr",  imem_addr,            16'h0020);
    chk("hlt_instr", instruction,          16'h0000);
    chk("hlt_valid", {15'd0, fetch_valid}, 16'h0001);
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'h4009);
      chk("hd_halt",  {15'd0, halted},      16'h0001);
      chk("hd_en",    {15'd0, imem_en},     16'h0000);
      chk("hd_valid", {15'd0, fetch_valid}, 16'h0000);
      chk("hd_fst",   {15'd0, fetch_stall}, 16'h0000);
      chk("hd_instr", instruction,          16'h0800);
      chk("hd_npc",   next_pc1,             16'h0022);
    end
    drive(1'b0, 1'b1, 16'h0030, 1'b0, 16'h0000);
    chk("hbr_halt", {15'd0, halted}, 16'h0001);
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    chk("res_addr", imem_addr,        16'h0030);
    chk("res_halt", {15'd0, halted},  16'h0000);
    chk("res_en",   {15'd0, imem_en}, 16'h0001);

    // Async reset in the middle of DRAIN
    drive(1'b0, 1'b1, 16'h0050, 1'b0, 16'h0000);
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    chk("ard_addr", imem_addr, 16'h0030);
    #1 rst = 1'b1;
    #1;
    chk("ar_en",  {15'd0, imem_en},     16'h0000);
    chk("ar_fst", {15'd0, fetch_stall}, 16'h0000);
    chk("ar_npc", next_pc1,             16'h0002);
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'h400A);
    chk("arr_addr",  imem_addr,            16'h0000);
    chk("arr_en",    {15'd0, imem_en},     16'h0001);
    chk("arr_valid", {15'd0, fetch_valid}, 16'h0001);
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'h400B);
    chk("arr2_addr", imem_addr, 16'h0002);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, PC value loaded on reset.
REQ-002 SHALL have parameter NOP_INSTR, default 16'h0800, instruction presented downstream when no valid fetch exists.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port stall  input  1  hazard-unit hold; the delivered instruction is discarded and PC holds.
REQ-006 SHALL have port branch_taken  input  1  redirect request from a later stage.
REQ-007 SHALL have port branch_target  input  16  redirect PC.
REQ-008 SHALL have port imem_rdata  input  16  instruction memory read data, valid when imem_done=1.
REQ-009 SHALL have port imem_done  input  1  memory completion for the outstanding request.
REQ-010 SHALL have port imem_en  output  1  memory read request, held high until imem_done.
REQ-011 SHALL have port imem_addr  output  16  request address, equal to pc while a request is outstanding.
REQ-012 SHALL have port instruction  output  16  instruction to the IF/ID register.
REQ-013 SHALL have port next_pc1  output  16  pc+2 of the current PC, to the IF/ID register.
REQ-014 SHALL have port fetch_valid  output  1  instruction carries a real fetched instruction this cycle.
REQ-015 SHALL have port fetch_stall  output  1  fetch is waiting on memory; downstream inserts bubbles.
REQ-016 SHALL have port halted  output  1  fetch has stopped on HALT.

Function
REQ-017 SHALL hold a 16-bit pc register and a 3-state FSM: FETCH, DRAIN, HALTED.
REQ-018 SHALL drive next_pc1 = pc + 2 modulo 2^16 combinationally; 16'hFFFE wraps to 16'h0000.
REQ-019 In FETCH, SHALL assert imem_en=1 and imem_addr=pc every cycle.
REQ-020 In FETCH with imem_done=1, SHALL drive instruction=imem_rdata and fetch_valid=1 in that same cycle (zero added latency).
REQ-021 In FETCH with imem_done=0, SHALL drive instruction=NOP_INSTR, fetch_valid=0, fetch_stall=1, and hold pc.
REQ-022 On a delivered fetch (FETCH, imem_done=1, stall=0, branch_taken=0), SHALL load pc <= pc+2, unless imem_rdata[15:11]=5'b00000 (HALT).
REQ-023 On a delivered HALT, SHALL keep pc unchanged and enter HALTED at the next edge; the HALT instruction itself is passed downstream with fetch_valid=1.
REQ-024 With stall=1 and no branch, SHALL hold pc and state; the memory result in that cycle is dropped and re-requested.
REQ-025 branch_taken=1 SHALL have priority over stall, HALT, and imem_done; pc <= branch_target at the next edge, and fetch_valid=0 in that cycle.
REQ-026 branch_taken in FETCH with imem_done=0 SHALL enter DRAIN; otherwise it SHALL stay in or return to FETCH.
REQ-027 In DRAIN, SHALL hold imem_en=1 at the old address, output NOP_INSTR with fetch_valid=0 and fetch_stall=1, and enter FETCH on imem_done (data discarded).
REQ-028 In DRAIN, a further branch_taken SHALL overwrite pc with the newest branch_target; the state remains DRAIN until imem_done.
REQ-029 In HALTED, SHALL drive imem_en=0, instruction=NOP_INSTR, fetch_valid=0, fetch_stall=0, and halted=1; pc SHALL be frozen.
REQ-030 In HALTED, branch_taken=1 SHALL load branch_target and return to FETCH (wrong-path HALT cancel); nothing else SHALL exit HALTED except rst.

Reset
REQ-031 rst=1 SHALL asynchronously force pc=RESET_PC and state=FETCH, independent of clk.
REQ-032 While rst=1, SHALL drive imem_en=0, instruction=NOP_INSTR, fetch_valid=0, fetch_stall=0, and halted=0.
REQ-033 Reset asserted mid-request (FETCH or DRAIN) SHALL abandon the request; the first request after deassertion SHALL be to RESET_PC.

Verification
REQ-034 Zero-wait memory, no stall, instructions 16'h4000 16'h4001: imem_addr 0000, 0002, 0004 on successive cycles; next_pc1 0002, 0004.
REQ-035 imem_done delayed 3 cycles at pc=0006: fetch_stall=1 and instruction=0800 for 3 cycles, then the data is delivered and pc becomes 0008.
REQ-036 stall=1 for 2 cycles at pc=0010: pc stays 0010, fetch_valid still follows imem_done, and pc becomes 0012 on the first unstalled delivery.
REQ-037 branch_taken with target 0040 and stall=1 in the same cycle: pc=0040 next cycle, and the delivered data is dropped.
REQ-038 branch_taken (target 0080) during a 2-cycle-pending fetch: DRAIN until done with old data dropped, and the next request is to 0080.
REQ-039 HALT (16'h0000) fetched at 0020: halted=1, imem_en=0, pc=0020 held; then branch_taken to 0030 resumes fetch at 0030; async rst mid-DRAIN restarts at 0000.
